// File: rtl/timer_bank_if.sv
// Peripheral rd/wr bus between the CPU and the timer bank, plus the IRQ
// line and the kernel-mode mask that rides alongside it.
interface timer_bank_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;
    logic        PC_31;

    modport slave  (input rd, wr, addr, wdata, PC_31, output rdata, irqout);
    modport master (output rd, wr, addr, wdata, PC_31, input rdata, irqout);
endinterface

// File: rtl/timer_bank.sv
// Bank of N_TIMERS independent prescaled timers on the peripheral bus.
// One timer_bank_ch per channel; the top only decodes the bus and ORs the IRQs.
module timer_bank_ch #(
    parameter int TIMER_W = 32,
    parameter int PRESC_W = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               i_wr_th,
    input  logic               i_wr_tl,
    input  logic               i_wr_tcon,
    input  logic               i_wr_presc,
    input  logic               i_w1c,
    input  logic [31:0]        i_wdata,
    output logic [TIMER_W-1:0] o_th,
    output logic [TIMER_W-1:0] o_tl,
    output logic [PRESC_W-1:0] o_presc,
    output logic [3:0]         o_tcon
);
    logic [TIMER_W-1:0] r_th;
    logic [TIMER_W-1:0] r_tl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_en;
    logic               r_ie;
    logic               r_stat;
    logic               r_oneshot;
    logic               w_tick;
    logic               w_wrap;

    assign w_tick = r_en && (r_pcnt == r_presc);
    // A bus write to TL on the same edge suppresses the overflow entirely.
    assign w_wrap = w_tick && (&r_tl) && !i_wr_tl;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_presc   <= '0;
            r_pcnt    <= '0;
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_stat    <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            if (i_wr_th)
                r_th <= i_wdata[TIMER_W-1:0];
            if (i_wr_presc)
                r_presc <= i_wdata[PRESC_W-1:0];

            if (i_wr_tl)
                r_tl <= i_wdata[TIMER_W-1:0];
            else if (w_wrap)
                r_tl <= r_th;
            else if (w_tick)
                r_tl <= r_tl + TIMER_W'(1);

            // Disabled channels hold pcnt at 0, which also covers the EN 0->1 restart.
            if (i_wr_presc || !r_en || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + PRESC_W'(1);

            if (i_wr_tcon) begin
                r_en      <= i_wdata[0];
                r_ie      <= i_wdata[1];
                r_oneshot <= i_wdata[3];
            end else if (w_wrap && r_oneshot) begin
                r_en <= 1'b0;
            end

            // Overflow set beats any clear arriving on the same edge.
            if (w_wrap)
                r_stat <= 1'b1;
            else if ((i_wr_tcon && i_wdata[2]) || i_w1c)
                r_stat <= 1'b0;
        end
    end

    assign o_th    = r_th;
    assign o_tl    = r_tl;
    assign o_presc = r_presc;
    assign o_tcon  = {r_oneshot, r_stat, r_ie, r_en};
endmodule

module timer_bank #(
    parameter int          N_TIMERS  = 4,
    parameter int          TIMER_W   = 32,
    parameter int          PRESC_W   = 16,
    parameter logic [31:0] BASE_ADDR = 32'h40000100
) (
    input  logic         sysclk,
    input  logic         reset,
    timer_bank_if.slave  bus
);
    localparam logic [31:0] PEND_OFF = 32'(16 * N_TIMERS);

    logic [31:0]                      w_off;
    logic                             w_hit;
    logic                             w_pend_sel;
    logic                             w_ch_sel;
    logic [2:0]                       w_ch;
    logic [1:0]                       w_reg;
    logic [N_TIMERS-1:0][TIMER_W-1:0] w_th;
    logic [N_TIMERS-1:0][TIMER_W-1:0] w_tl;
    logic [N_TIMERS-1:0][PRESC_W-1:0] w_presc;
    logic [N_TIMERS-1:0][3:0]         w_tcon;
    logic [N_TIMERS-1:0][3:0]         w_wr_sel;
    logic [N_TIMERS-1:0]              w_stat;
    logic [N_TIMERS-1:0]              w_ie;
    logic [31:0]                      w_rdata;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign w_off      = bus.addr - BASE_ADDR;
    assign w_hit      = (bus.addr[1:0] == 2'b00) && (w_off <= PEND_OFF);
    assign w_pend_sel = w_hit && (w_off == PEND_OFF);
    assign w_ch_sel   = w_hit && !w_pend_sel;
    assign w_ch       = w_off[6:4];
    assign w_reg      = w_off[3:2];

    generate
        for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
            for (genvar r = 0; r < 4; r++) begin : g_sel
                assign w_wr_sel[g][r] = bus.wr && w_ch_sel && (w_ch == 3'(g)) && (w_reg == 2'(r));
            end

            timer_bank_ch #(
                .TIMER_W (TIMER_W),
                .PRESC_W (PRESC_W)
            ) u_ch (
                .sysclk     (sysclk),
                .reset      (reset),
                .i_wr_th    (w_wr_sel[g][0]),
                .i_wr_tl    (w_wr_sel[g][1]),
                .i_wr_tcon  (w_wr_sel[g][2]),
                .i_wr_presc (w_wr_sel[g][3]),
                .i_w1c      (bus.wr && w_pend_sel && bus.wdata[g]),
                .i_wdata    (bus.wdata),
                .o_th       (w_th[g]),
                .o_tl       (w_tl[g]),
                .o_presc    (w_presc[g]),
                .o_tcon     (w_tcon[g])
            );

            assign w_stat[g] = w_tcon[g][2];
            assign w_ie[g]   = w_tcon[g][1];
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (bus.rd && w_pend_sel) begin
            w_rdata = 32'(w_stat);
        end else if (bus.rd && w_ch_sel) begin
            for (int i = 0; i < N_TIMERS; i++) begin
                if (w_ch == 3'(i)) begin
                    case (w_reg)
                        2'd0:    w_rdata = 32'(w_th[i]);
                        2'd1:    w_rdata = 32'(w_tl[i]);
                        2'd2:    w_rdata = 32'(w_tcon[i]);
                        default: w_rdata = 32'(w_presc[i]);
                    endcase
                end
            end
        end
    end

    assign bus.rdata  = w_rdata;
    assign bus.irqout = ~bus.PC_31 & (|(w_stat & w_ie));
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: inputs change and outputs are sampled just after
// the falling edge, so every register update lands on the following rising edge.
module tb_timer_bank;
    localparam logic [31:0] BASE = 32'h40000100;
    localparam logic [31:0] PEND = BASE + 32'h40;

    logic sysclk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    timer_bank_if bus();

    timer_bank #(
        .N_TIMERS  (4),
        .TIMER_W   (32),
        .PRESC_W   (16),
        .BASE_ADDR (BASE)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [31:0] ra(input int ch, input int r);
        return BASE + 32'(16 * ch + 4 * r);
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(negedge sysclk);
        bus.wr    = 1'b0;
    endtask

    task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        chk(bus.rdata, exp, tag);
        bus.rd   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.PC_31 = 1'b0;

        // power-on reset
        #2 reset = 1'b0;
        #1 chk({31'b0, bus.irqout}, 32'd0, "rst_irq");
        rdc(ra(0, 1), 32'h0, "rst_tl0");
        @(negedge sysclk);
        rdc(ra(1, 2), 32'h0, "rst_tcon1");
        reset = 1'b1;
        idle(1);

        // ch0 free-run overflow with reload, then W1C through TCON
        wr(ra(0, 0), 32'hFFFF_FFF0);
        wr(ra(0, 1), 32'hFFFF_FFFD);
        wr(ra(0, 3), 32'h0);
        wr(ra(0, 2), 32'h3);
        idle(2);
        rdc(ra(0, 1), 32'hFFFF_FFFF, "s2_tl_pre");
        rdc(ra(0, 2), 32'h3, "s2_stat_pre");
        idle(1);
        rdc(ra(0, 1), 32'hFFFF_FFF0, "s2_tl_reload");
        rdc(ra(0, 2), 32'h7, "s2_stat_set");
        chk({31'b0, bus.irqout}, 32'd1, "s2_irq_on");
        wr(ra(0, 2), 32'h7);
        rdc(ra(0, 2), 32'h3, "s2_w1c");
        rdc(ra(0, 1), 32'hFFFF_FFF1, "s2_tl_after");
        chk({31'b0, bus.irqout}, 32'd0, "s2_irq_off");
        wr(ra(0, 2), 32'h0);

        // ch1 prescaler=3: one tick per 4 cycles, PRESC rewrite restarts period
        wr(ra(1, 3), 32'h3);
        wr(ra(1, 1), 32'h0);
        wr(ra(1, 2), 32'h1);
        idle(3);
        rdc(ra(1, 1), 32'h0, "s3_tl_3cyc");
        idle(1);
        rdc(ra(1, 1), 32'h1, "s3_tl_4cyc");
        idle(4);
        rdc(ra(1, 1), 32'h2, "s3_tl_8cyc");
        idle(2);
        wr(ra(1, 3), 32'h3);
        idle(3);
        rdc(ra(1, 1), 32'h2, "s3_restart_hold");
        idle(1);
        rdc(ra(1, 1), 32'h3, "s3_restart_tick");
        wr(ra(1, 2), 32'h0);

        // ch2 one-shot, irqout masked by PC_31
        bus.PC_31 = 1'b1;
        wr(ra(2, 0), 32'h5);
        wr(ra(2, 1), 32'hFFFF_FFFF);
        wr(ra(2, 2), 32'hB);
        rdc(ra(2, 1), 32'hFFFF_FFFF, "s4_tl_pre");
        idle(1);
        rdc(ra(2, 1), 32'h5, "s4_tl_reload");
        rdc(ra(2, 2), 32'hE, "s4_tcon_stop");
        chk({31'b0, bus.irqout}, 32'd0, "s4_irq_masked");
        idle(3);
        rdc(ra(2, 1), 32'h5, "s4_tl_hold");
        bus.PC_31 = 1'b0;
        #1 chk({31'b0, bus.irqout}, 32'd1, "s4_irq_unmasked");
        wr(PEND, 32'h4);
        rdc(ra(2, 2), 32'hA, "s4_pend_w1c");
        chk({31'b0, bus.irqout}, 32'd0, "s4_irq_cleared");

        // ch3 collisions: TL write vs overflow, IRQ_PEND W1C vs overflow
        wr(ra(3, 0), 32'h100);
        wr(ra(3, 1), 32'hFFFF_FFFE);
        wr(ra(3, 2), 32'h1);
        idle(1);
        wr(ra(3, 1), 32'h1234);
        rdc(ra(3, 1), 32'h1234, "s5_tl_coll");
        rdc(ra(3, 2), 32'h1, "s5_tl_coll_stat");
        wr(ra(3, 1), 32'hFFFF_FFFE);
        idle(1);
        wr(PEND, 32'h8);
        rdc(ra(3, 2), 32'h5, "s5_w1c_coll");
        rdc(ra(3, 1), 32'h100, "s5_w1c_coll_tl");
        wr(ra(3, 2), 32'h0);
        rdc(ra(3, 2), 32'h4, "s5_stat_kept");
        rdc(ra(3, 1), 32'h101, "s5_tl_last");

        // ch0 TCON write (EN=0) on the overflow edge: STAT still sets
        wr(ra(0, 1), 32'hFFFF_FFFF);
        wr(ra(0, 2), 32'h1);
        wr(ra(0, 2), 32'h0);
        rdc(ra(0, 2), 32'h4, "s6_tcon_coll");
        rdc(ra(0, 1), 32'hFFFF_FFF0, "s6_tl0");
        rdc(PEND, 32'h9, "s6_pend");
        idle(1);

        // decode holes
        rdc(BASE + 32'h44, 32'h0, "s6_unmapped_rd");
        rdc(BASE + 32'h36, 32'h0, "s6_misalign_rd");
        bus.addr = ra(0, 0);
        bus.rd   = 1'b0;
        #1 chk(bus.rdata, 32'h0, "s6_rd_low");
        idle(1);
        wr(BASE + 32'h44, 32'hFFFF_FFFF);
        wr(BASE + 32'h36, 32'h0);
        wr(BASE - 32'h4, 32'h0);
        rdc(ra(3, 1), 32'h101, "s6_tl3_kept");
        rdc(ra(0, 0), 32'hFFFF_FFF0, "s6_th0_kept");
        rdc(PEND, 32'h9, "s6_pend_kept");
        idle(1);
        rdc(ra(0, 1), 32'hFFFF_FFF0, "s6_tl0_kept");
        rdc(ra(3, 0), 32'h100, "s6_th3_kept");
        chk({31'b0, bus.irqout}, 32'd0, "s6_irq_ie_off");
        wr(ra(3, 2), 32'h2);
        chk({31'b0, bus.irqout}, 32'd1, "s6_irq_ie_late");
        rdc(ra(3, 2), 32'h6, "s6_tcon3_ie");

        // asynchronous reset in the middle of a count
        wr(ra(1, 2), 32'h1);
        idle(2);
        #2 reset = 1'b0;
        #1 chk({31'b0, bus.irqout}, 32'd0, "rst_mid_irq");
        rdc(ra(1, 1), 32'h0, "rst_mid_tl1");
        rdc(ra(3, 2), 32'h0, "rst_mid_tcon3");
        rdc(PEND, 32'h0, "rst_mid_pend");
        rdc(ra(0, 0), 32'h0, "rst_mid_th0");
        rdc(ra(1, 3), 32'h0, "rst_mid_presc1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
